pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have the following parameters:
- N, default 32, datapath and address width.
- DEPTH, default 32, instruction-memory depth in words.
- RESET_PC, default 0, byte address fetched first after reset.

REQ-002 The block SHALL have the following ports, clock and reset first:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- stall, input, 1, hold PC and fetch register.
- branch_taken, input, 1, take the conditional branch this cycle.
- branch_offset, input, N, sign-extended word offset (imm16).
- jump, input, 1, take the absolute jump this cycle.
- jump_target, input, 26, J-format target field.
- instr_in, input, N, instruction word from instruction memory.
- imem_addr, output, N, word index to instruction memory.
- pc, output, N, current byte PC.
- pc_plus4, output, N, pc+4.
- instr_out, output, N, registered fetched instruction.
- instr_pc, output, N, byte PC of instr_out.
- instr_valid, output, 1, instr_out holds a real instruction.
- halted, output, 1, fetch has stopped (PC out of range).
- fetch_count, output, 16, count of valid fetches.

Function
REQ-003 imem_addr SHALL equal pc>>2 (zero-filled), combinationally.
REQ-004 pc_plus4 SHALL equal pc+4 modulo 2^N.
REQ-005 Next-PC priority SHALL be reset > halted > stall > jump > branch_taken > sequential.
REQ-006 The jump target SHALL be {pc_plus4[N-1:28], jump_target, 2'b00}.
REQ-007 The branch target SHALL be pc_plus4 + (branch_offset<<2), modulo 2^N, with wrap-around permitted.
REQ-008 The FSM SHALL have the states BOOT, RUN and HALT:
- BOOT: entered on reset; instr_valid=0; goes to RUN after one cycle.
- RUN: goes to HALT when the next-PC word index is >= DEPTH.
- HALT: left only by reset.
REQ-009 In RUN, when not stalled, each clock SHALL latch instr_in into instr_out and pc into instr_pc, set instr_valid=1, and load pc with the selected next-PC.
REQ-010 Redirect: when jump or branch_taken is accepted, the instruction latched in that cycle SHALL be marked instr_valid=0 (one-bubble flush).
REQ-011 When stall=1, pc, instr_out, instr_pc, instr_valid and fetch_count SHALL hold, and jump and branch_taken SHALL be ignored.
REQ-012 When jump and branch_taken are asserted together, jump SHALL win.
REQ-013 In HALT, pc SHALL freeze, instr_valid=0 and halted=1.
REQ-014 fetch_count SHALL increment on each cycle that sets instr_valid=1, and SHALL saturate at 16'hFFFF.

Reset
REQ-015 With reset=1 at a clock edge, the block SHALL set:
- pc=RESET_PC
- instr_out=0, instr_pc=0, instr_valid=0
- halted=0, fetch_count=0
- state=BOOT
REQ-016 Reset asserted mid-stall, mid-redirect or in HALT SHALL override all other inputs on the same edge.

Structure
REQ-017 N, DEPTH, RESET_PC defaults and the FSM state encoding SHALL live in the shared package mips_pkg.
REQ-018 The next-PC selection SHALL be one combinational sub-module, next_pc_sel; all registers and the FSM SHALL stay in pc_fetch_unit.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Reset then 4 free-running cycles: pc 0 -> 4 -> 8 -> 12; imem_addr 0,1,2,3; instr_valid 0 in BOOT, then 1; fetch_count=3.
- branch_taken=1 with branch_offset=-2 at pc=16: next pc=12; the flushed slot has instr_valid=0.
- jump=1 and branch_taken=1 together, jump_target=3, at pc=8: next pc=12 (jump wins).
- stall=1 for 3 cycles at pc=20: pc, instr_out and fetch_count unchanged; jump pulsed during the stall is ignored.
- Sequential fetch reaching pc=124 (DEPTH=32): next index 32 -> HALT; halted=1; pc frozen at 124.
- Reset asserted while halted: pc=0, halted=0, state BOOT on the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared defaults and fetch FSM encoding for the MIPS front end.
package mips_pkg;

  localparam int unsigned MIPS_N        = 32;
  localparam int unsigned MIPS_DEPTH    = 32;
  localparam int unsigned MIPS_RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC mux: jump > branch > sequential. Stall/halt gating lives in the fetch FSM.
module next_pc_sel
  import mips_pkg::*;
#(
  parameter int N = MIPS_N
) (
  input  logic [N-1:0] i_pc,
  input  logic         i_jump,
  input  logic         i_branch_taken,
  input  logic [N-1:0] i_branch_offset,
  input  logic [25:0]  i_jump_target,
  output logic [N-1:0] o_pc_plus4,
  output logic [N-1:0] o_next_pc,
  output logic         o_redirect
);

  logic [N-1:0] w_br_target;
  logic [N-1:0] w_j_target;

  assign o_pc_plus4  = i_pc + N'(4);
  // Offset is in words; the add wraps modulo 2^N by construction.
  assign w_br_target = o_pc_plus4 + (i_branch_offset << 2);
  assign w_j_target  = {o_pc_plus4[N-1:28], i_jump_target, 2'b00};
  assign o_redirect  = i_jump | i_branch_taken;

  always_comb begin
    o_next_pc = o_pc_plus4;
    if (i_jump)              o_next_pc = w_j_target;
    else if (i_branch_taken) o_next_pc = w_br_target;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, fetch latch and BOOT/RUN/HALT control.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int          N        = MIPS_N,
  parameter int          DEPTH    = MIPS_DEPTH,
  parameter int unsigned RESET_PC = MIPS_RESET_PC
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_offset,
  input  logic         jump,
  input  logic [25:0]  jump_target,
  input  logic [N-1:0] instr_in,
  output logic [N-1:0] imem_addr,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus4,
  output logic [N-1:0] instr_out,
  output logic [N-1:0] instr_pc,
  output logic         instr_valid,
  output logic         halted,
  output logic [15:0]  fetch_count
);

  fetch_state_t r_state;
  logic [N-1:0] r_pc;
  logic [N-1:0] r_instr_out;
  logic [N-1:0] r_instr_pc;
  logic         r_instr_valid;
  logic         r_halted;
  logic [15:0]  r_fetch_count;

  logic [N-1:0] w_next_pc;
  logic         w_redirect;
  logic         w_next_oob;

  next_pc_sel #(.N(N)) u_sel (
    .i_pc            (r_pc),
    .i_jump          (jump),
    .i_branch_taken  (branch_taken),
    .i_branch_offset (branch_offset),
    .i_jump_target   (jump_target),
    .o_pc_plus4      (pc_plus4),
    .o_next_pc       (w_next_pc),
    .o_redirect      (w_redirect)
  );

  assign imem_addr  = {2'b00, r_pc[N-1:2]};
  assign w_next_oob = (w_next_pc >> 2) >= N'(DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_BOOT;
      r_pc          <= N'(RESET_PC);
      r_instr_out   <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: if (!stall) begin
          // Leaving the memory window freezes pc at the last in-range address.
          if (w_next_oob) begin
            r_state       <= ST_HALT;
            r_halted      <= 1'b1;
            r_instr_valid <= 1'b0;
          end else begin
            r_pc          <= w_next_pc;
            r_instr_out   <= instr_in;
            r_instr_pc    <= r_pc;
            r_instr_valid <= !w_redirect;
            if (!w_redirect && r_fetch_count != 16'hFFFF)
              r_fetch_count <= r_fetch_count + 16'd1;
          end
        end
        ST_HALT: begin
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b1;
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign pc          = r_pc;
  assign instr_out   = r_instr_out;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign halted      = r_halted;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: stimulus queues expected state, monitor compares on negedge.
module tb_pc_fetch_unit;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset, stall, branch_taken, jump;
  logic [N-1:0]  branch_offset, instr_in, imem_addr, pc, pc_plus4, instr_out, instr_pc;
  logic [25:0]   jump_target;
  logic          instr_valid, halted;
  logic [15:0]   fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        halted;
    logic        valid;
    logic [15:0] cnt;
    logic        chk_io;
    logic [31:0] io;
  } st_t;

  typedef struct {
    logic [31:0] ipc;
    logic [31:0] iword;
  } fx_t;

  st_t stq[$];
  fx_t fq[$];
  st_t e;
  fx_t f;
  logic [15:0] last_cnt = '0;

  always #5 clk = ~clk;

  // Instruction memory model: word at index k is C0DE_0000 | k.
  assign instr_in = 32'hC0DE_0000 | imem_addr;

  pc_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .instr_in      (instr_in),
    .imem_addr     (imem_addr),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .instr_out     (instr_out),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: per-cycle status, plus instruction checks whenever a new valid fetch appears.
  always @(negedge clk) begin
    if (stq.size() > 0) begin
      e = stq.pop_front();
      chk("pc", pc, e.pc);
      chk("imem_addr", imem_addr, e.pc >> 2);
      chk("pc_plus4", pc_plus4, e.pc + 32'd4);
      chk("halted", {31'd0, halted}, {31'd0, e.halted});
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, e.valid});
      chk("fetch_count", {16'd0, fetch_count}, {16'd0, e.cnt});
      if (e.chk_io) chk("instr_out_hold", instr_out, e.io);
    end
    if (instr_valid === 1'b1 && fetch_count !== last_cnt) begin
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL fetch_unexpected actual_pc=%h expected=none", instr_pc);
      end else begin
        f = fq.pop_front();
        chk("instr_pc", instr_pc, f.ipc);
        chk("instr_out", instr_out, f.iword);
      end
    end
    last_cnt = fetch_count;
  end

  task automatic step(input logic r, input logic s, input logic b, input logic [31:0] off,
                      input logic j, input logic [25:0] jt,
                      input logic [31:0] epc, input logic eh, input logic ev,
                      input logic [15:0] ec, input logic cio, input logic [31:0] eio);
    reset = r; stall = s; branch_taken = b; branch_offset = off; jump = j; jump_target = jt;
    @(posedge clk);
    #1;
    stq.push_back('{epc, eh, ev, ec, cio, eio});
  endtask

  // Plain sequential cycle; the word fetched is the one at the previous pc.
  task automatic seq(input logic [31:0] epc, input logic [15:0] ec);
    step(0, 0, 0, 32'd0, 0, 26'd0, epc, 0, 1, ec, 0, 32'd0);
    fq.push_back('{epc - 32'd4, 32'hC0DE_0000 | ((epc - 32'd4) >> 2)});
  endtask

  initial begin
    // Reset, BOOT, then free-running fetch
    step(1, 0, 0, 32'd0, 0, 26'd0, 32'd0, 0, 0, 16'd0, 1, 32'd0);
    step(0, 0, 0, 32'd0, 0, 26'd0, 32'd0, 0, 0, 16'd0, 0, 32'd0);
    seq(32'd4, 16'd1);
    seq(32'd8, 16'd2);
    seq(32'd12, 16'd3);
    seq(32'd16, 16'd4);
    // Branch -2 words from pc=16: 20 - 8 = 12, flushed slot
    step(0, 0, 1, 32'hFFFF_FFFE, 0, 26'd0, 32'd12, 0, 0, 16'd4, 0, 32'd0);
    seq(32'd16, 16'd5);
    seq(32'd20, 16'd6);
    // Stall 3 cycles at pc=20, jump pulsed mid-stall must be ignored
    step(0, 1, 0, 32'd0, 0, 26'd0, 32'd20, 0, 1, 16'd6, 1, 32'hC0DE_0004);
    step(0, 1, 0, 32'd0, 1, 26'd3, 32'd20, 0, 1, 16'd6, 1, 32'hC0DE_0004);
    step(0, 1, 0, 32'd0, 0, 26'd0, 32'd20, 0, 1, 16'd6, 1, 32'hC0DE_0004);
    seq(32'd24, 16'd7);
    for (int p = 28; p <= 124; p += 4) seq(32'(p), 16'(7 + (p - 24) / 4));
    // pc=124 -> next index 32 is out of range: halt with pc frozen
    step(0, 0, 0, 32'd0, 0, 26'd0, 32'd124, 1, 0, 16'd32, 0, 32'd0);
    step(0, 0, 0, 32'd0, 0, 26'd0, 32'd124, 1, 0, 16'd32, 0, 32'd0);
    step(0, 0, 1, 32'd1, 1, 26'd3, 32'd124, 1, 0, 16'd32, 0, 32'd0);
    // Reset wins over stall/jump/branch while halted
    step(1, 1, 1, 32'd8, 1, 26'd5, 32'd0, 0, 0, 16'd0, 1, 32'd0);
    step(0, 0, 0, 32'd0, 0, 26'd0, 32'd0, 0, 0, 16'd0, 0, 32'd0);
    seq(32'd4, 16'd1);
    seq(32'd8, 16'd2);
    // Jump and branch together at pc=8: jump to {0, 3, 00} = 12
    step(0, 0, 1, 32'd5, 1, 26'd3, 32'd12, 0, 0, 16'd2, 0, 32'd0);
    seq(32'd16, 16'd3);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("status_queue_drained", 32'(stq.size()), 32'd0);
    chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
